// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared states, unit counts and ASCII-to-Morse code table
package morse_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOOKUP,
      MARK,
      SPACE,
      LGAP,
      WGAP
   } state_t;

   localparam int DOT_U        = 1;
   localparam int DASH_U       = 3;
   localparam int ELEM_GAP_U   = 1;
   localparam int LGAP_U       = 3;
   localparam int WGAP_EXTRA_U = 4;

   localparam logic [7:0] ASCII_SPACE = 8'h20;

   // Returns {len[2:0], pat[4:0]}; pat[0] is sent first, 1 = dash, 0 = dot.
   // len = 0 marks a byte with no Morse encoding.
   function automatic logic [7:0] morse_code(input logic [7:0] c);
      logic [7:0] u;
      logic [7:0] code;
      u = ((c >= 8'h61) && (c <= 8'h7a)) ? (c - 8'h20) : c;
      case (u)
         8'h41: code = {3'd2, 5'b00010}; // A .-
         8'h42: code = {3'd4, 5'b00001}; // B -...
         8'h43: code = {3'd4, 5'b00101}; // C -.-.
         8'h44: code = {3'd3, 5'b00001}; // D -..
         8'h45: code = {3'd1, 5'b00000}; // E .
         8'h46: code = {3'd4, 5'b00100}; // F ..-.
         8'h47: code = {3'd3, 5'b00011}; // G --.
         8'h48: code = {3'd4, 5'b00000}; // H ....
         8'h49: code = {3'd2, 5'b00000}; // I ..
         8'h4a: code = {3'd4, 5'b01110}; // J .---
         8'h4b: code = {3'd3, 5'b00101}; // K -.-
         8'h4c: code = {3'd4, 5'b00010}; // L .-..
         8'h4d: code = {3'd2, 5'b00011}; // M --
         8'h4e: code = {3'd2, 5'b00001}; // N -.
         8'h4f: code = {3'd3, 5'b00111}; // O ---
         8'h50: code = {3'd4, 5'b00110}; // P .--.
         8'h51: code = {3'd4, 5'b01011}; // Q --.-
         8'h52: code = {3'd3, 5'b00010}; // R .-.
         8'h53: code = {3'd3, 5'b00000}; // S ...
         8'h54: code = {3'd1, 5'b00001}; // T -
         8'h55: code = {3'd3, 5'b00100}; // U ..-
         8'h56: code = {3'd4, 5'b01000}; // V ...-
         8'h57: code = {3'd3, 5'b00110}; // W .--
         8'h58: code = {3'd4, 5'b01001}; // X -..-
         8'h59: code = {3'd4, 5'b01101}; // Y -.--
         8'h5a: code = {3'd4, 5'b00011}; // Z --..
         8'h30: code = {3'd5, 5'b11111}; // 0 -----
         8'h31: code = {3'd5, 5'b11110}; // 1 .----
         8'h32: code = {3'd5, 5'b11100}; // 2 ..---
         8'h33: code = {3'd5, 5'b11000}; // 3 ...--
         8'h34: code = {3'd5, 5'b10000}; // 4 ....-
         8'h35: code = {3'd5, 5'b00000}; // 5 .....
         8'h36: code = {3'd5, 5'b00001}; // 6 -....
         8'h37: code = {3'd5, 5'b00011}; // 7 --...
         8'h38: code = {3'd5, 5'b00111}; // 8 ---..
         8'h39: code = {3'd5, 5'b01111}; // 9 ----.
         default: code = 8'h00;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// rtl/morse_unit_timer.sv - Morse unit prescaler with clear and wrap tick
module morse_unit_timer
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 6_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   output logic unit_tick_o
);

   localparam int            CW   = $clog2(UNIT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(UNIT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // The tick must not depend on clear_i: clear is derived from the FSM's
   // next state, which itself depends on this tick.
   assign unit_tick_o = (cnt_q == LAST);

   // Next count: restart on state entry or on wrap, otherwise advance.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clear_i || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ascii_to_morse_encoder.sv
// rtl/ascii_to_morse_encoder.sv - UART rx FIFO bytes to Morse key line; SIDETONE_EN adds a gated sidetone
module ascii_to_morse_encoder
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 6_000_000,
   parameter int TONE_HALF   = 50_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] r_data,
   input  logic       rx_empty,
   output logic       rd_uart,
   output logic       key,
   output logic       tone,
   output logic       busy
);

   state_t     state_q;
   state_t     state_d;
   logic [2:0] elem_q;
   logic [2:0] elem_d;
   logic [1:0] units_q;
   logic [1:0] units_d;
   logic [7:0] char_q;
   logic [7:0] char_d;

   logic [7:0] code;
   logic [2:0] code_len;
   logic [4:0] code_pat;
   logic [1:0] last_unit;
   logic       unit_tick;
   logic       unit_clear;

   // The code word is re-derived from the latched byte; char_q is stable
   // from LOOKUP until the character has been sent.
   assign code     = morse_code(char_q);
   assign code_len = code[7:5];
   assign code_pat = code[4:0];

   // Restarting the prescaler on every state entry makes each state last an
   // exact multiple of UNIT_CYCLES.
   assign unit_clear = (state_d != state_q);

   morse_unit_timer #(
      .UNIT_CYCLES (UNIT_CYCLES)
   ) u_unit_timer (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (unit_clear),
      .unit_tick_o (unit_tick)
   );

   // Next-state and Moore outputs of the key sequencer.
   always_comb begin
      state_d   = state_q;
      elem_d    = elem_q;
      char_d    = char_q;
      rd_uart   = 1'b0;
      key       = 1'b0;
      busy      = 1'b1;
      last_unit = 2'd0;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (!rx_empty) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            rd_uart = 1'b1;
            char_d  = r_data;
            state_d = LOOKUP;
         end
         LOOKUP: begin
            if (char_q == ASCII_SPACE) begin
               state_d = WGAP;
            end else if (code_len != 3'd0) begin
               elem_d  = 3'd0;
               state_d = MARK;
            end else begin
               state_d = IDLE;
            end
         end
         MARK: begin
            key       = 1'b1;
            last_unit = code_pat[elem_q] ? 2'(DASH_U - 1) : 2'(DOT_U - 1);
            if (unit_tick && (units_q == last_unit)) begin
               state_d = ((elem_q + 3'd1) < code_len) ? SPACE : LGAP;
            end
         end
         SPACE: begin
            last_unit = 2'(ELEM_GAP_U - 1);
            if (unit_tick && (units_q == last_unit)) begin
               elem_d  = elem_q + 3'd1;
               state_d = MARK;
            end
         end
         LGAP: begin
            last_unit = 2'(LGAP_U - 1);
            if (unit_tick && (units_q == last_unit)) begin
               state_d = IDLE;
            end
         end
         WGAP: begin
            last_unit = 2'(WGAP_EXTRA_U - 1);
            if (unit_tick && (units_q == last_unit)) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Unit counter: restarts on state entry, otherwise counts unit ticks.
   always_comb begin
      units_d = units_q;
      if (unit_clear) begin
         units_d = 2'd0;
      end else if (unit_tick) begin
         units_d = units_q + 2'd1;
      end
   end

   // Sequencer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         elem_q  <= 3'd0;
         units_q <= 2'd0;
         char_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         elem_q  <= elem_d;
         units_q <= units_d;
         char_q  <= char_d;
      end
   end

`ifdef SIDETONE_EN
   localparam int            TW        = $clog2(TONE_HALF + 1);
   localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);

   logic [TW-1:0] tdiv_q;
   logic [TW-1:0] tdiv_d;
   logic          tone_q;
   logic          tone_d;

   // Sidetone divider: runs only during a mark and restarts from silence.
   always_comb begin
      tdiv_d = tdiv_q + TW'(1);
      tone_d = tone_q;
      if (!key) begin
         tdiv_d = '0;
         tone_d = 1'b0;
      end else if (tdiv_q == TONE_LAST) begin
         tdiv_d = '0;
         tone_d = ~tone_q;
      end
   end

   // Sidetone registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         tdiv_q <= '0;
         tone_q <= 1'b0;
      end else begin
         tdiv_q <= tdiv_d;
         tone_q <= tone_d;
      end
   end

   assign tone = tone_q & key;
`else
   assign tone = 1'b0;
`endif

endmodule

// File: tb/tb_ascii_to_morse_encoder.sv
// tb/tb_ascii_to_morse_encoder.sv - randomized self-checking bench against a Morse timing model
module tb_ascii_to_morse_encoder;

   localparam int U  = 4;
   localparam int TH = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] r_data;
   logic       rx_empty;
   logic       rd_uart;
   logic       key;
   logic       tone;
   logic       busy;

   int         checks = 0;
   int         errors = 0;
   int         prot_viol = 0;
   logic       prev_rd = 1'b0;

   logic [7:0] fifo[$];
   logic [3:0] exp_q[$];   // {key, busy, rd_uart, tone} per cycle
   logic [3:0] obs_q[$];
   string      tbl[36];

   ascii_to_morse_encoder #(
      .UNIT_CYCLES (U),
      .TONE_HALF   (TH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .r_data   (r_data),
      .rx_empty (rx_empty),
      .rd_uart  (rd_uart),
      .key      (key),
      .tone     (tone),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic init_table();
      tbl = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
              ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
              "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
              "-----", ".----", "..---", "...--", "....-", ".....", "-....",
              "--...", "---..", "----."};
   endtask

   function automatic string code_of(input logic [7:0] c);
      if (c >= 8'h41 && c <= 8'h5a) return tbl[int'(c) - 8'h41];
      if (c >= 8'h61 && c <= 8'h7a) return tbl[int'(c) - 8'h61];
      if (c >= 8'h30 && c <= 8'h39) return tbl[26 + int'(c) - 8'h30];
      return "";
   endfunction

   function automatic logic tone_at(input int j);
`ifdef SIDETONE_EN
      return ((j / TH) % 2) == 1;
`else
      return (j < 0);
`endif
   endfunction

   // Expected per-cycle trace of one byte, starting at the IDLE cycle that sees it.
   task automatic model_byte(input logic [7:0] c);
      string s;
      int    n;
      s = code_of(c);
      exp_q.push_back(4'b0000);
      exp_q.push_back(4'b0110);
      exp_q.push_back(4'b0100);
      if (c == 8'h20) begin
         repeat (4 * U) exp_q.push_back(4'b0100);
      end else if (s.len() > 0) begin
         for (int i = 0; i < s.len(); i++) begin
            n = (s[i] == 8'h2d) ? 3 * U : U;
            for (int j = 0; j < n; j++) exp_q.push_back({1'b1, 1'b1, 1'b0, tone_at(j)});
            if (i < s.len() - 1) repeat (U) exp_q.push_back(4'b0100);
         end
         repeat (3 * U) exp_q.push_back(4'b0100);
      end
   endtask

   task automatic drive_fifo();
      rx_empty = (fifo.size() == 0);
      r_data   = (fifo.size() == 0) ? 8'h00 : fifo[0];
   endtask

   task automatic run(input int n);
      logic pop;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         obs_q.push_back({key, busy, rd_uart, tone});
         if (rd_uart && (rx_empty || prev_rd)) prot_viol++;
         prev_rd = rd_uart;
         pop = rd_uart;
         @(posedge clk);
         #1;
         if (pop && fifo.size() > 0) void'(fifo.pop_front());
         drive_fifo();
      end
   endtask

   task automatic play();
      exp_q.delete();
      obs_q.delete();
      foreach (fifo[i]) model_byte(fifo[i]);
      repeat (3) exp_q.push_back(4'b0000);
      drive_fifo();
      run(exp_q.size());
   endtask

   function automatic int first_diff();
      if (obs_q.size() != exp_q.size()) return 0;
      foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   function automatic int count_bit(input int b);
      int n;
      n = 0;
      foreach (obs_q[i]) if (obs_q[i][b]) n++;
      return n;
   endfunction

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({key, busy, rd_uart, tone} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs got %b want 0000", {key, busy, rd_uart, tone});
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_e();
      int d;
      fifo.push_back(8'h45);
      play();
      d = first_diff();
      checks++;
      if (d >= 0) begin
         errors++;
         $display("FAIL e_trace cycle %0d got %b want %b", d, obs_q[d], exp_q[d]);
      end
      checks++;
      if (count_bit(1) != 1) begin
         errors++;
         $display("FAIL e_rd_pulses got %0d want 1", count_bit(1));
      end
   endtask

   task automatic test_a_upper_lower();
      int d;
      logic [7:0] chars[2];
      chars = '{8'h41, 8'h61};
      foreach (chars[k]) begin
         fifo.push_back(chars[k]);
         play();
         d = first_diff();
         checks++;
         if (d >= 0) begin
            errors++;
            $display("FAIL a_trace char %h cycle %0d got %b want %b", chars[k], d, obs_q[d], exp_q[d]);
         end
      end
   endtask

   task automatic test_zero();
      int d;
      fifo.push_back(8'h30);
      play();
      d = first_diff();
      checks++;
      if (d >= 0) begin
         errors++;
         $display("FAIL zero_trace cycle %0d got %b want %b", d, obs_q[d], exp_q[d]);
      end
      checks++;
      if (count_bit(3) != 5 * 3 * U) begin
         errors++;
         $display("FAIL zero_mark_cycles got %0d want %0d", count_bit(3), 5 * 3 * U);
      end
   endtask

   task automatic test_space_hash();
      int d;
      logic [7:0] chars[2];
      int busy_want[2];
      chars = '{8'h20, 8'h23};
      busy_want = '{2 + 4 * U, 2};
      foreach (chars[k]) begin
         fifo.push_back(chars[k]);
         play();
         d = first_diff();
         checks++;
         if (d >= 0) begin
            errors++;
            $display("FAIL gap_trace char %h cycle %0d got %b want %b", chars[k], d, obs_q[d], exp_q[d]);
         end
         checks++;
         if (count_bit(2) != busy_want[k] || count_bit(3) != 0) begin
            errors++;
            $display("FAIL gap_busy char %h got busy %0d key %0d want busy %0d key 0",
                     chars[k], count_bit(2), count_bit(3), busy_want[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int d;
      int fall;
      int rise;
      fifo.push_back(8'h45);
      fifo.push_back(8'h45);
      play();
      d = first_diff();
      checks++;
      if (d >= 0) begin
         errors++;
         $display("FAIL ee_trace cycle %0d got %b want %b", d, obs_q[d], exp_q[d]);
      end
      fall = -1;
      rise = -1;
      foreach (obs_q[i]) begin
         if (i > 0 && fall < 0 && !obs_q[i][3] && obs_q[i-1][3]) fall = i;
         else if (fall >= 0 && rise < 0 && obs_q[i][3]) rise = i;
      end
      checks++;
      // low cycles between the marks: letter gap, then IDLE, FETCH, LOOKUP
      if (rise - fall != 3 * U + 3) begin
         errors++;
         $display("FAIL ee_gap got %0d want %0d", rise - fall, 3 * U + 3);
      end
      checks++;
      if (count_bit(1) != 2) begin
         errors++;
         $display("FAIL ee_rd_pulses got %0d want 2", count_bit(1));
      end
   endtask

   task automatic test_reset_mid();
      int d;
      int waited;
      logic rose;
      logic [3:0] last;
      obs_q.delete();
      fifo.push_back(8'h54);
      drive_fifo();
      rose = 1'b0;
      waited = 0;
      while (!rose && waited < 20) begin
         run(1);
         waited++;
         last = obs_q[obs_q.size() - 1];
         rose = last[3];
      end
      checks++;
      if (!rose) begin
         errors++;
         $display("FAIL t_key_rise got none within %0d cycles want rise", waited);
      end
      run(4);
      last = obs_q[obs_q.size() - 1];
      checks++;
      if (last[3] !== 1'b1) begin
         errors++;
         $display("FAIL t_in_dash got key %b want 1", last[3]);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      prev_rd = 1'b0;
      fifo.delete();
      drive_fifo();
      @(negedge clk);
      checks++;
      if ({key, busy, rd_uart, tone} !== 4'b0000) begin
         errors++;
         $display("FAIL mid_reset got %b want 0000", {key, busy, rd_uart, tone});
      end
      @(posedge clk);
      #1;
      fifo.push_back(8'h45);
      play();
      d = first_diff();
      checks++;
      if (d >= 0) begin
         errors++;
         $display("FAIL after_reset_trace cycle %0d got %b want %b", d, obs_q[d], exp_q[d]);
      end
   endtask

   task automatic test_random();
      int d;
      logic [7:0] c;
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 6; k++) begin
            case ($urandom_range(0, 4))
               0: c = 8'h41 + 8'($urandom_range(0, 25));
               1: c = 8'h61 + 8'($urandom_range(0, 25));
               2: c = 8'h30 + 8'($urandom_range(0, 9));
               3: c = 8'h20;
               default: c = 8'($urandom);
            endcase
            fifo.push_back(c);
         end
         play();
         d = first_diff();
         checks++;
         if (d >= 0) begin
            errors++;
            $display("FAIL random_trace round %0d cycle %0d got %b want %b", r, d, obs_q[d], exp_q[d]);
         end
      end
   endtask

   task automatic test_protocol();
      checks++;
      if (prot_viol != 0) begin
         errors++;
         $display("FAIL rd_uart_protocol got %0d violations want 0", prot_viol);
      end
   endtask

   initial begin
      init_table();
      reset = 1'b1;
      fifo.delete();
      drive_fifo();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_e();
      test_a_upper_lower();
      test_zero();
      test_space_hash();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_protocol();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
